sap_clk_gate_ctrl: RTL and testbench
====================================

Name: sap_clk_gate_ctrl

Overview:
- Controller that drives the enable input of a clock-gate cell (e.g. sap_clock_gate en_i / test_en_i) for one gated clock domain.
- Watches an idle indication from the gated domain and gates its clock after a programmable run of consecutive idle cycles.
- Re-enables the clock on a wake request and signals when the clock is running and settled.
- Runs on the free-running (ungated) clock upstream of the gate.

Parameters:
- IDLE_CYCLES, 16, consecutive qualifying idle cycles before gating; legal range >= 1.
- WAKE_CYCLES, 2, settle cycles after re-enable before clk_active_o rises; 0 is legal.
- CNT_W, 16, width of the saturating gating-event counter.

Ports:
- clk_i  in  1  free-running clock.
- rst_i  in  1  reset, synchronous, active-high.
- idle_i  in  1  gated domain reports idle; level, sampled every cycle.
- wake_req_i  in  1  request to run the gated clock; level or pulse.
- sw_force_i  in  1  software keep-on; blocks gating, also wakes.
- test_en_i  in  1  scan/test bypass; forces gate_en_o high.
- gate_en_o  out  1  enable to the clock gate.
- clk_active_o  out  1  gated clock is running and settled.
- state_o  out  2  FSM state: RUN=0, IDLE_WAIT=1, GATED=2, WAKE=3.
- gate_count_o  out  CNT_W  number of entries into GATED; saturates at all-ones.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: state RUN, gate_en_o=1 (when test_en_i=0), clk_active_o=1, idle counter 0, wake counter 0, gate_count_o=0. The domain clock runs out of reset.
- Output timing:
  - gate_en_o = en_q OR test_en_i. The test_en_i term is the only combinational path.
  - All other outputs are registered.
- qual = idle_i AND NOT wake_req_i AND NOT sw_force_i. Wake and force always win over idle.
- RUN (en_q=1, active=1):
  - qual=1 and IDLE_CYCLES=1 -> GATED.
  - qual=1 otherwise -> IDLE_WAIT, idle_cnt=1.
  - qual=0 -> stay in RUN.
- IDLE_WAIT (en_q=1, active=1):
  - qual=0 -> RUN, idle_cnt=0.
  - qual=1 and idle_cnt==IDLE_CYCLES-1 -> GATED.
  - qual=1 otherwise -> idle_cnt+1.
- Gating therefore happens exactly at the edge that samples the IDLE_CYCLES-th consecutive qualifying cycle. On that same edge en_q and active both go to 0.
- Entering GATED increments gate_count_o, saturating at 2^CNT_W-1.
- GATED (en_q=0, active=0):
  - idle_i is ignored.
  - wake_req_i OR sw_force_i -> WAKE with en_q=1 and wake_cnt=0. If WAKE_CYCLES=0, go directly to RUN with en_q=1 and active=1 on that edge.
- WAKE (en_q=1, active=0):
  - wake_cnt increments each cycle.
  - When wake_cnt==WAKE_CYCLES-1 -> RUN, active=1.
  - Inputs are ignored during WAKE; no re-gating is possible until back in RUN.
- test_en_i:
  - Affects only gate_en_o. The FSM, counters and clk_active_o evolve exactly as with test_en_i=0.
- Reset asserted in any state, including mid-WAKE or mid-IDLE_WAIT, returns to the reset values on the next edge. gate_count_o also clears.
- wake_req_i held continuously keeps the FSM in RUN.
- A one-cycle wake pulse in GATED is sufficient; it is not required to be held.

Test Plan (IDLE_CYCLES=4, WAKE_CYCLES=2, CNT_W=16):
1. Reset: assert rst_i for 2 cycles with idle_i=1 -> during and after reset gate_en_o=1, clk_active_o=1, state_o=0, gate_count_o=0.
2. idle_i=1 constant from the edge after reset release -> state_o goes 1,1,1 on edges 1-3. On edge 4: state_o=2, gate_en_o=0, clk_active_o=0, gate_count_o=1.
3. idle_i=1 for 3 cycles, 0 for 1 cycle, then 1 -> state returns to 0 after the drop. Gating happens only 4 edges after idle_i reasserts; gate_count_o=1.
4. In GATED, 1-cycle wake_req_i pulse -> next edge: gate_en_o=1, state_o=3, clk_active_o=0. After 2 more edges: state_o=0, clk_active_o=1. With idle_i=1 held, re-gating after 4 more edges gives gate_count_o=2.
5. In GATED, drive test_en_i=1 -> gate_en_o=1 in the same cycle, state_o stays 2, clk_active_o stays 0. Release test_en_i -> gate_en_o=0.
6. sw_force_i=1 with idle_i=1 -> never leaves RUN. Separately: assert rst_i during WAKE -> next edge state_o=0, clk_active_o=1, gate_count_o=0.

Source files
------------

// File: rtl/sap_clk_gate_ctrl.sv
// Clock-gate enable controller: gates a domain clock after a run of consecutive
// qualifying idle cycles and re-enables it with a settle delay on wake or force.
module sap_clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idle_i,
    input  logic             wake_req_i,
    input  logic             sw_force_i,
    input  logic             test_en_i,
    output logic             gate_en_o,
    output logic             clk_active_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] gate_count_o
);

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        GATED     = 2'd2,
        WAKE      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idle_cnt_q, idle_cnt_d;
    logic [WW-1:0]     wake_cnt_q, wake_cnt_d;
    logic              en_q, en_d;
    logic              active_q, active_d;
    logic [CNT_W-1:0]  gate_count_q, gate_count_d;
    logic              qual;
    logic              wake_any;

    assign wake_any = wake_req_i | sw_force_i;
    assign qual     = idle_i & ~wake_any;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            idle_cnt_q   <= '0;
            wake_cnt_q   <= '0;
            en_q         <= 1'b1;
            active_q     <= 1'b1;
            gate_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            wake_cnt_q   <= wake_cnt_d;
            en_q         <= en_d;
            active_q     <= active_d;
            gate_count_q <= gate_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            RUN: begin
                idle_cnt_d = '0;
                if (qual) begin
                    if (IDLE_CYCLES == 1) begin
                        state_d = GATED;
                    end else begin
                        state_d    = IDLE_WAIT;
                        idle_cnt_d = IW'(1);
                    end
                end
            end
            IDLE_WAIT: begin
                if (!qual) begin
                    state_d    = RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = GATED;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
            GATED: begin
                // idle_i is deliberately ignored while the clock is stopped
                if (wake_any) begin
                    state_d    = (WAKE_CYCLES == 0) ? RUN : WAKE;
                    wake_cnt_d = '0;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = RUN;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + WW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Registered outputs are decoded from the next state so they change on the same edge.
    always_comb begin
        en_d         = (state_d != GATED);
        active_d     = (state_d == RUN) || (state_d == IDLE_WAIT);
        gate_count_d = gate_count_q;
        if (state_d == GATED && state_q != GATED && gate_count_q != '1) begin
            gate_count_d = gate_count_q + CNT_W'(1);
        end
    end

    assign gate_en_o    = en_q | test_en_i;
    assign clk_active_o = active_q;
    assign state_o      = state_q;
    assign gate_count_o = gate_count_q;

endmodule

// File: tb/tb_sap_clk_gate_ctrl.sv
// Directed and randomized checks of sap_clk_gate_ctrl against a behavioural
// model built from idle-streak / wake-countdown bookkeeping.
module tb_sap_clk_gate_ctrl;

    localparam int IDLE_CYCLES = 4;
    localparam int WAKE_CYCLES = 2;
    localparam int CNT_W       = 16;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             idle_i = 1'b1;
    logic             wake_req_i = 1'b0;
    logic             sw_force_i = 1'b0;
    logic             test_en_i = 1'b0;
    logic             gate_en_o;
    logic             clk_active_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] gate_count_o;

    int tests = 0;
    int fails = 0;

    // reference model
    int m_gated = 0;
    int m_wake_left = 0;
    int m_streak = 0;
    int m_count = 0;

    sap_clk_gate_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .idle_i      (idle_i),
        .wake_req_i  (wake_req_i),
        .sw_force_i  (sw_force_i),
        .test_en_i   (test_en_i),
        .gate_en_o   (gate_en_o),
        .clk_active_o(clk_active_o),
        .state_o     (state_o),
        .gate_count_o(gate_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int max_cnt;
        max_cnt = (1 << CNT_W) - 1;
        if (rst_i) begin
            m_gated = 0; m_wake_left = 0; m_streak = 0; m_count = 0;
        end else if (m_gated != 0) begin
            if (wake_req_i || sw_force_i) begin
                m_gated     = 0;
                m_wake_left = WAKE_CYCLES;
                m_streak    = 0;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (idle_i && !wake_req_i && !sw_force_i) begin
            m_streak++;
            if (m_streak == IDLE_CYCLES) begin
                m_gated  = 1;
                m_streak = 0;
                if (m_count < max_cnt) m_count++;
            end
        end else begin
            m_streak = 0;
        end
    endtask

    function automatic int m_state();
        if (m_gated != 0) return 2;
        if (m_wake_left > 0) return 3;
        if (m_streak > 0) return 1;
        return 0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".state"},  32'(state_o),      32'(m_state()));
        check({tag, ".active"}, 32'(clk_active_o), 32'((m_gated == 0) && (m_wake_left == 0)));
        check({tag, ".gate_en"}, 32'(gate_en_o),   32'((m_gated == 0) || test_en_i));
        check({tag, ".count"},  32'(gate_count_o), 32'(m_count));
    endtask

    // One clock edge: model follows the inputs sampled at the edge, outputs checked 1ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        // 1. reset
        rst_i = 1'b1; idle_i = 1'b1;
        repeat (2) begin
            step("rst");
            check("rst.state", 32'(state_o), 0);
            check("rst.gate_en", 32'(gate_en_o), 1);
            check("rst.active", 32'(clk_active_o), 1);
            check("rst.count", 32'(gate_count_o), 0);
        end
        rst_i = 1'b0;

        // 2. continuous idle gates on the 4th edge
        for (int i = 0; i < 3; i++) begin
            step("idle_run");
            check("idle_run.state", 32'(state_o), 1);
        end
        step("gate");
        check("gate.state", 32'(state_o), 2);
        check("gate.gate_en", 32'(gate_en_o), 0);
        check("gate.active", 32'(clk_active_o), 0);
        check("gate.count", 32'(gate_count_o), 1);

        // 5. test_en bypass while gated
        test_en_i = 1'b1;
        #1;
        check("test_en.comb", 32'(gate_en_o), 1);
        step("test_en");
        check("test_en.state", 32'(state_o), 2);
        check("test_en.active", 32'(clk_active_o), 0);
        test_en_i = 1'b0;
        #1;
        check("test_en.release", 32'(gate_en_o), 0);

        // 4. single-cycle wake pulse
        wake_req_i = 1'b1;
        step("wake");
        check("wake.state", 32'(state_o), 3);
        check("wake.gate_en", 32'(gate_en_o), 1);
        check("wake.active", 32'(clk_active_o), 0);
        wake_req_i = 1'b0;
        step("settle1");
        check("settle1.state", 32'(state_o), 3);
        step("settle2");
        check("settle2.state", 32'(state_o), 0);
        check("settle2.active", 32'(clk_active_o), 1);
        repeat (3) step("regate_wait");
        step("regate");
        check("regate.state", 32'(state_o), 2);
        check("regate.count", 32'(gate_count_o), 2);

        // 3. interrupted idle run restarts the streak
        rst_i = 1'b1;
        repeat (2) step("rst2");
        rst_i = 1'b0;
        repeat (3) step("streak_a");
        idle_i = 1'b0;
        step("drop");
        check("drop.state", 32'(state_o), 0);
        idle_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("streak_b");
            check("streak_b.state", 32'(state_o), 1);
        end
        step("gate2");
        check("gate2.state", 32'(state_o), 2);
        check("gate2.count", 32'(gate_count_o), 1);

        // 6. reset in the middle of WAKE
        wake_req_i = 1'b1;
        step("wake2");
        wake_req_i = 1'b0;
        rst_i = 1'b1;
        step("rst_wake");
        check("rst_wake.state", 32'(state_o), 0);
        check("rst_wake.active", 32'(clk_active_o), 1);
        check("rst_wake.count", 32'(gate_count_o), 0);
        rst_i = 1'b0;

        // 6. force keep-on, then held wake, both with idle asserted
        sw_force_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("force");
            check("force.state", 32'(state_o), 0);
        end
        sw_force_i = 1'b0;
        wake_req_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step("wake_held");
            check("wake_held.state", 32'(state_o), 0);
        end
        wake_req_i = 1'b0;

        // randomized traffic, idle-heavy so gating and waking both occur often
        for (int i = 0; i < 3000; i++) begin
            idle_i     = ($urandom_range(0, 9) < 8);
            wake_req_i = ($urandom_range(0, 19) == 0);
            sw_force_i = ($urandom_range(0, 39) == 0);
            test_en_i  = ($urandom_range(0, 9) == 0);
            rst_i      = ($urandom_range(0, 199) == 0);
            #1;
            check("rand.comb_gate_en", 32'(gate_en_o), 32'((m_gated == 0) || test_en_i));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
